hazard_interlock: RTL

- Pipeline interlock controller for the decode stage.
- Tracks destination registers in flight in EX, MEM and WB, and detects RAW hazards against the instruction in ID.
- On a hazard it stalls PC and the IF/ID register and injects bubbles into ID/EX.
- Sequences the multi-cycle multiply in EX, and optionally generates registered forwarding selects for EX operands.

---
 rtl/hazard_interlock_if.sv | 49 ++++
 rtl/hazard_interlock.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/hazard_interlock_if.sv
// -----------------------------------------------------------------------------
// hazard_interlock_if
// Bundle between the decode stage (master) and the interlock controller
// (slave).
//
// Handshake: id_valid qualifies every id_* field. stall is the inverse of
// ready. An instruction issues from ID into EX on a rising edge where
// id_valid=1 and stall=0. While stall=1 the master must hold the id_* fields
// stable.
//
// Signals
//   master -> slave : id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
//                     id_rd, id_regwrite, id_load, id_branch, id_mul
//   slave -> master : stall, bubble, ex_hold, fwd_a, fwd_b,
//                     dbg_mul_busy (multiply FSM state, 1 = MUL)
// -----------------------------------------------------------------------------
interface hazard_interlock_if #(
  parameter int REG_W = 6
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs1;
  logic             id_rs1_used;
  logic [REG_W-1:0] id_rs2;
  logic             id_rs2_used;
  logic [REG_W-1:0] id_rd;
  logic             id_regwrite;
  logic             id_load;
  logic             id_branch;
  logic             id_mul;

  logic             stall;
  logic             bubble;
  logic             ex_hold;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             dbg_mul_busy;

  modport master (
    output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
           id_rd, id_regwrite, id_load, id_branch, id_mul,
    input  stall, bubble, ex_hold, fwd_a, fwd_b, dbg_mul_busy
  );

  modport slave (
    input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
           id_rd, id_regwrite, id_load, id_branch, id_mul,
    output stall, bubble, ex_hold, fwd_a, fwd_b, dbg_mul_busy
  );
endinterface

// File: rtl/hazard_interlock.sv
// -----------------------------------------------------------------------------
// hazard_interlock
// Decode-stage interlock controller. It tracks destination registers in flight
// in EX, MEM and WB and detects RAW hazards against the ID instruction. It
// stalls PC and IF/ID and bubbles ID/EX. It also sequences the multi-cycle
// multiply in EX.
//
// Optional macro HAZARD_FORWARD_EN:
//   defined   - only unavoidable hazards stall (load-use, branch operands).
//               Registered forwarding selects are produced for EX operands.
//   undefined - any in-flight producer stalls. fwd_a and fwd_b are tied to 00.
//
// Ports
//   clk   : pipeline clock, all state updates on posedge
//   reset : asynchronous, active-high, clears all state
//   bus   : hazard_interlock_if.slave (ID fields in, stall/bubble/ex_hold/
//           fwd_a/fwd_b/dbg_mul_busy out)
//
// fwd encoding: 00 regfile, 01 EX/MEM result, 10 WB value.
// -----------------------------------------------------------------------------
module hazard_interlock #(
  parameter int REG_W   = 6,
  parameter int MUL_LAT = 4     // 2..15
) (
  input logic               clk,
  input logic               reset,
  hazard_interlock_if.slave bus
);

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} mul_state_t;

  // Tracking slots {valid, rd, load}
  logic             r_ex_v,  r_mem_v,  r_wb_v;
  logic [REG_W-1:0] r_ex_rd, r_mem_rd, r_wb_rd;
  logic             r_ex_ld, r_mem_ld, r_wb_ld;

  mul_state_t r_state;
  logic [3:0] r_cnt;
  logic       r_ex_hold;

  logic w_hazard;
  logic w_stall;
  logic w_issue;

  // Integer register 0 never creates a dependency. FP register 0 (6'h20) does.
  function automatic logic slot_match(input logic v, input logic [REG_W-1:0] rd,
                                      input logic [REG_W-1:0] src, input logic used);
    return v && used && (rd == src) && (rd != '0);
  endfunction

  logic w_ex_m1, w_ex_m2, w_mem_m1, w_mem_m2;
  assign w_ex_m1  = slot_match(r_ex_v,  r_ex_rd,  bus.id_rs1, bus.id_rs1_used);
  assign w_ex_m2  = slot_match(r_ex_v,  r_ex_rd,  bus.id_rs2, bus.id_rs2_used);
  assign w_mem_m1 = slot_match(r_mem_v, r_mem_rd, bus.id_rs1, bus.id_rs1_used);
  assign w_mem_m2 = slot_match(r_mem_v, r_mem_rd, bus.id_rs2, bus.id_rs2_used);

`ifdef HAZARD_FORWARD_EN
  logic w_ex_any, w_mem_any;
  assign w_ex_any  = w_ex_m1 | w_ex_m2;
  assign w_mem_any = w_mem_m1 | w_mem_m2;

  // Load data is not ready for EX forwarding. The branch compare in ID sits
  // ahead of the EX/MEM forwarding paths and can only use MEM values that
  // are not pending loads.
  assign w_hazard = bus.id_valid &
                    ((w_ex_any & r_ex_ld) |
                     (bus.id_branch & w_ex_any) |
                     (bus.id_branch & w_mem_any & r_mem_ld));
`else
  logic w_wb_m1, w_wb_m2;
  assign w_wb_m1 = slot_match(r_wb_v, r_wb_rd, bus.id_rs1, bus.id_rs1_used);
  assign w_wb_m2 = slot_match(r_wb_v, r_wb_rd, bus.id_rs2, bus.id_rs2_used);

  assign w_hazard = bus.id_valid &
                    (w_ex_m1 | w_ex_m2 | w_mem_m1 | w_mem_m2 | w_wb_m1 | w_wb_m2);
`endif

  assign w_stall = r_ex_hold | w_hazard;
  assign w_issue = bus.id_valid & ~w_stall;

  assign bus.stall        = w_stall;
  // While a multiply holds EX, ID/EX is frozen rather than bubbled.
  assign bus.bubble       = w_stall & ~r_ex_hold;
  assign bus.ex_hold      = r_ex_hold;
  assign bus.dbg_mul_busy = (r_state == S_MUL);

  // Slot pipeline
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_v   <= 1'b0;  r_ex_rd  <= '0;  r_ex_ld  <= 1'b0;
      r_mem_v  <= 1'b0;  r_mem_rd <= '0;  r_mem_ld <= 1'b0;
      r_wb_v   <= 1'b0;  r_wb_rd  <= '0;  r_wb_ld  <= 1'b0;
    end else begin
      r_wb_v  <= r_mem_v;
      r_wb_rd <= r_mem_rd;
      r_wb_ld <= r_mem_ld;
      if (r_ex_hold) begin
        // EX keeps the multiply, and EX/MEM takes a bubble.
        r_mem_v <= 1'b0;
      end else begin
        r_mem_v  <= r_ex_v;
        r_mem_rd <= r_ex_rd;
        r_mem_ld <= r_ex_ld;
        r_ex_v   <= w_issue & bus.id_regwrite;
        r_ex_rd  <= bus.id_rd;
        r_ex_ld  <= bus.id_load;
      end
    end
  end

  // Multiply FSM. The issue cycle plus MUL_LAT-1 held cycles give exactly
  // MUL_LAT cycles of EX occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_ex_hold <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue && bus.id_mul) begin
            r_state   <= S_MUL;
            r_cnt     <= 4'(MUL_LAT - 1);
            r_ex_hold <= 1'b1;
          end
        end
        S_MUL: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state   <= S_IDLE;
            r_ex_hold <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_cnt     <= 4'd0;
          r_ex_hold <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAZARD_FORWARD_EN
  logic [1:0] r_fwd_a, r_fwd_b;

  // The youngest matching producer wins: EX before MEM.
  function automatic logic [1:0] fwd_sel(input logic m_ex, input logic m_mem);
    return m_ex ? 2'b01 : (m_mem ? 2'b10 : 2'b00);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fwd_a <= 2'b00;
      r_fwd_b <= 2'b00;
    end else if (!r_ex_hold) begin
      if (w_issue) begin
        r_fwd_a <= fwd_sel(w_ex_m1, w_mem_m1);
        r_fwd_b <= fwd_sel(w_ex_m2, w_mem_m2);
      end else begin
        r_fwd_a <= 2'b00;
        r_fwd_b <= 2'b00;
      end
    end
  end

  assign bus.fwd_a = r_fwd_a;
  assign bus.fwd_b = r_fwd_b;
`else
  assign bus.fwd_a = 2'b00;
  assign bus.fwd_b = 2'b00;
`endif

  // Slot fields that one of the build variants leaves unread.
  logic w_unused;
  assign w_unused = ^{bus.id_branch, r_ex_ld, r_mem_ld, r_wb_v, r_wb_rd, r_wb_ld};

endmodule
